// File: rtl/hgcal_input_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hgcal_input_packer
// Purpose  : Packs 2-bit feature beats into a full layer-0 input vector and
//            presents it double-buffered (assembly + output) with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module hgcal_input_packer #(
  parameter int IN_BITS        = 2,
  parameter int FEATS_PER_BEAT = 4,
  parameter int NUM_FEATS      = 48,
  parameter int DROP_W         = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic                                s_sof,
  input  logic [FEATS_PER_BEAT*IN_BITS-1:0]   s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [NUM_FEATS*IN_BITS-1:0]        m_data,
  output logic [DROP_W-1:0]                   drop_cnt
);

  localparam int C_BEAT_W = FEATS_PER_BEAT * IN_BITS;
  localparam int C_VEC_W  = NUM_FEATS * IN_BITS;
  localparam int C_BEATS  = NUM_FEATS / FEATS_PER_BEAT;
  localparam int C_CNT_W  = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_asm_full;
  logic [C_VEC_W-1:0] r_asm;
  logic [C_VEC_W-1:0] r_m_data;
  logic               r_m_valid;
  logic [DROP_W-1:0]  r_drop;

  logic               w_accept;
  logic               w_out_free;
  logic               w_store;
  logic               w_drop;
  logic               w_complete;
  logic [C_CNT_W-1:0] w_idx;
  logic [C_VEC_W-1:0] w_vec;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic               w_asm_full_nxt;
  logic               w_m_valid_nxt;
  logic [C_VEC_W-1:0] w_m_data_nxt;
  logic [DROP_W-1:0]  w_drop_nxt;

  always_comb begin
    w_accept   = s_valid && !r_asm_full;
    w_out_free = !r_m_valid || m_ready;
    // A sof beat always restarts at beat 0; a non-sof beat is only kept mid-frame.
    w_store    = w_accept && (s_sof || (r_cnt != '0));
    w_drop     = w_accept && ((r_cnt == '0) ? !s_sof : s_sof);
    w_idx      = s_sof ? '0 : r_cnt;
    w_complete = w_store && (w_idx == C_CNT_W'(C_BEATS - 1));

    w_vec = r_asm;
    for (int b = 0; b < C_BEATS; b++) begin
      if (w_store && (w_idx == C_CNT_W'(b))) begin
        w_vec[b*C_BEAT_W +: C_BEAT_W] = s_data;
      end
    end

    w_cnt_nxt = r_cnt;
    if (w_store) begin
      w_cnt_nxt = w_complete ? '0 : (w_idx + C_CNT_W'(1));
    end

    w_asm_full_nxt = r_asm_full;
    w_m_valid_nxt  = r_m_valid;
    w_m_data_nxt   = r_m_data;
    if (r_asm_full) begin
      if (r_m_valid && m_ready) begin
        w_m_data_nxt   = r_asm;
        w_asm_full_nxt = 1'b0;
      end
    end else if (w_complete) begin
      if (w_out_free) begin
        w_m_data_nxt  = w_vec;
        w_m_valid_nxt = 1'b1;
      end else begin
        w_asm_full_nxt = 1'b1;
      end
    end else if (r_m_valid && m_ready) begin
      w_m_valid_nxt = 1'b0;
    end

    w_drop_nxt = r_drop;
    if (w_drop && (r_drop != '1)) begin
      w_drop_nxt = r_drop + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_asm_full <= 1'b0;
      r_asm      <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_asm_full <= w_asm_full_nxt;
      r_asm      <= w_vec;
      r_m_data   <= w_m_data_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  assign s_ready  = !r_asm_full;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_hgcal_input_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hgcal_input_packer
// Purpose  : Self-checking bench: directed table, corner sequences and random
//            traffic against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hgcal_input_packer;

  localparam int NB = 12;
  localparam int VW = 96;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_sof, m_valid, m_ready;
  logic [7:0]    s_data;
  logic [VW-1:0] m_data;
  logic [7:0]    drop_cnt;

  hgcal_input_packer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: completed vectors waiting to be consumed (at most two
  // fit: output buffer + held frame), the partial frame, and the drop count.
  logic [VW-1:0] q[$];
  logic [7:0]    mb[NB];
  int            mcnt, mdrop, dut_hs;

  typedef struct {
    logic       v, sof;
    logic [7:0] d;
    logic       mr;
    logic       er, ev;
    logic [7:0] edrop;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] beatd(input int mode, input int k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'(8'hFF - k);
      2:       return 8'hE4;
      default: return 8'(8'h30 + 7 * k);
    endcase
  endfunction

  function automatic logic [VW-1:0] framev(input int mode);
    logic [VW-1:0] v;
    for (int k = 0; k < NB; k++) v[k*8 +: 8] = beatd(mode, k);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    mcnt  = 0;
    mdrop = 0;
  endtask

  task automatic bump_drop();
    if (mdrop < 255) mdrop++;
  endtask

  // One clock: drive, check model at negedge, advance model at posedge.
  task automatic cycle(input logic v, input logic sof, input logic [7:0] d, input logic mr);
    logic hs, acc;
    logic [VW-1:0] vec;
    s_valid = v; s_sof = sof; s_data = d; m_ready = mr;
    @(negedge clk);
    chk("s_ready", VW'(s_ready), VW'(q.size() < 2));
    chk("m_valid", VW'(m_valid), VW'(q.size() > 0));
    if (q.size() > 0) chk("m_data", m_data, q[0]);
    chk("drop_cnt", VW'(drop_cnt), VW'(mdrop));
    if (m_valid && mr) dut_hs++;
    @(posedge clk);
    hs  = (q.size() > 0) && mr;
    acc = v && (q.size() < 2);
    if (hs) void'(q.pop_front());
    if (acc) begin
      if (sof) begin
        if (mcnt != 0) bump_drop();
        mb[0] = d;
        mcnt  = 1;
      end else if (mcnt == 0) begin
        bump_drop();
      end else begin
        mb[mcnt] = d;
        mcnt++;
      end
      if (mcnt == NB) begin
        for (int k = 0; k < NB; k++) vec[k*8 +: 8] = mb[k];
        q.push_back(vec);
        mcnt = 0;
      end
    end
    #1;
  endtask

  task automatic send_frame(input int mode, input logic mr);
    for (int k = 0; k < NB; k++) cycle(1'b1, k == 0, beatd(mode, k), mr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, h0;
    dut_hs = 0;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", VW'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_drop", VW'(drop_cnt), '0);
    chk("rst_s_ready", VW'(s_ready), VW'(1));
    rst = 1'b0;

    // Single frame of 8'hE4, consumer always ready.
    for (int k = 0; k < NB; k++) begin
      cycle(1'b1, k == 0, 8'hE4, 1'b1);
      chk("t1_s_ready", VW'(s_ready), VW'(1));
      chk("t1_m_valid", VW'(m_valid), VW'(k == NB - 1));
    end
    chk("t1_m_data", m_data, {12{8'hE4}});
    chk("t1_drop", VW'(drop_cnt), '0);

    // Table: three stray beats from IDLE, then a valid frame, then idle.
    for (int i = 0; i < 3; i++)
      tbl[i] = '{v: 1'b1, sof: 1'b0, d: 8'hAA, mr: 1'b1, er: 1'b1, ev: 1'b0, edrop: 8'(i + 1)};
    for (int k = 0; k < NB; k++)
      tbl[3 + k] = '{v: 1'b1, sof: (k == 0), d: beatd(3, k), mr: 1'b1, er: 1'b1,
                     ev: (k == NB - 1), edrop: 8'd3};
    tbl[15] = '{v: 1'b0, sof: 1'b0, d: 8'h00, mr: 1'b1, er: 1'b1, ev: 1'b0, edrop: 8'd3};
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].mr);
      chk("tbl_s_ready", VW'(s_ready), VW'(tbl[i].er));
      chk("tbl_m_valid", VW'(m_valid), VW'(tbl[i].ev));
      chk("tbl_drop", VW'(drop_cnt), VW'(tbl[i].edrop));
      if (i == 14) chk("tbl_m_data", m_data, framev(3));
    end

    // Back-to-back frames under back-pressure: A held, B waits in HOLD.
    send_frame(0, 1'b0);
    send_frame(1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("bb_s_ready_hold", VW'(s_ready), '0);
    chk("bb_m_valid_hold", VW'(m_valid), VW'(1));
    chk("bb_m_data_a", m_data, framev(0));
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bb_m_valid_nobubble", VW'(m_valid), VW'(1));
    chk("bb_m_data_b", m_data, framev(1));
    chk("bb_s_ready_back", VW'(s_ready), VW'(1));
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bb_m_valid_drain", VW'(m_valid), '0);

    // Frame abandoned by sof at beat 5, followed by a clean frame.
    d0 = int'(drop_cnt);
    h0 = dut_hs;
    for (int k = 0; k < 5; k++) cycle(1'b1, k == 0, 8'h5A, 1'b1);
    send_frame(1, 1'b1);
    chk("sof5_m_data", m_data, framev(1));
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sof5_drop_delta", VW'(int'(drop_cnt) - d0), VW'(1));
    chk("sof5_out_count", VW'(dut_hs - h0), VW'(1));

    // Asynchronous reset mid-frame while an output is pending.
    send_frame(3, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b1, k == 0, 8'h11, 1'b0);
    chk("ar_pre_m_valid", VW'(m_valid), VW'(1));
    s_valid = 1'b0; m_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_m_valid", VW'(m_valid), '0);
    chk("ar_drop", VW'(drop_cnt), '0);
    chk("ar_m_data", m_data, '0);
    model_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(0, 1'b1);
    chk("ar_frame_valid", VW'(m_valid), VW'(1));
    chk("ar_frame_data", m_data, framev(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(3) != 0, $urandom_range(12) == 0, 8'($urandom), $urandom_range(3) != 0);

    // Stray beats until the drop counter saturates.
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 8'h0F, 1'b1);
    chk("sat_drop", VW'(drop_cnt), VW'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hgcal_input_packer.md
Name: hgcal_input_packer

Overview:
- Upstream feeder for the quantized HGCAL autoencoder layer-0 LUT array.
- Accepts a stream of 2-bit quantized sensor codes, FEATS_PER_BEAT codes per beat, and assembles a full NUM_FEATS-code input vector.
- Presents the vector, double-buffered, with valid/ready to the layer-0 neuron fan-out. Ingest of frame N+1 overlaps drain of frame N.

Parameters:
- IN_BITS, 2, bits per quantized feature code.
- FEATS_PER_BEAT, 4, codes per input beat; s_data width = FEATS_PER_BEAT*IN_BITS (8).
- NUM_FEATS, 48, codes per frame; must be a multiple of FEATS_PER_BEAT. BEATS = NUM_FEATS/FEATS_PER_BEAT (12).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_sof  in  1  beat is the first beat of a frame.
- s_data  in  FEATS_PER_BEAT*IN_BITS  lane j = bits [j*IN_BITS +: IN_BITS].
- m_valid  out  1  output vector valid.
- m_ready  in  1  consumer accepts when m_valid&&m_ready.
- m_data  out  NUM_FEATS*IN_BITS  feature i at bits [i*IN_BITS +: IN_BITS].
- drop_cnt  out  DROP_W  count of discarded beats/partial frames, saturating.

Behaviour:
- Reset (async, immediate): beat counter cnt=0; assembly register, m_data=0; m_valid=0; asm_full=0; drop_cnt=0; s_ready=1 after rst deasserts. Reset mid-frame discards everything; no partial output.
- Placement: beat k (0-based), lane j writes feature k*FEATS_PER_BEAT+j.
- States:
  - IDLE (cnt==0, !asm_full).
  - FILL (0<cnt<BEATS).
  - HOLD (asm_full: complete frame waiting for output buffer).
- IDLE: accepted beat with s_sof=1 is stored as beat 0, cnt=1 (FILL). Accepted beat with s_sof=0 is consumed and discarded, drop_cnt+1, stay IDLE.
- FILL, accepted beat with s_sof=0: stored at beat cnt, cnt+1.
- FILL, accepted beat with s_sof=1: partial frame abandoned, drop_cnt+1. Beat is stored as new beat 0, cnt=1. Stale lanes need not be cleared; every lane is overwritten before completion.
- BEATS==1 edge: a sof beat in IDLE completes the frame immediately.
- Completion, when the accepted beat is beat BEATS-1:
  - If the output buffer is free at that edge (!m_valid, or m_valid&&m_ready), the full vector, including this beat's data, loads into m_data at the same edge. m_valid=1 next cycle; cnt=0.
  - Otherwise asm_full=1 (HOLD), cnt=0.
  - Latency: last beat accepted at edge t → m_valid high from edge t.
- HOLD:
  - s_ready=0.
  - On the first edge where m_valid&&m_ready, the assembly register transfers to m_data, m_valid stays 1, asm_full=0, and s_ready=1 the following cycle.
- s_ready = !asm_full (combinational from registers only; no dependence on s_valid or m_ready).
- Output: m_data and m_valid hold stable while m_valid&&!m_ready. m_valid falls after a handshake only if no new vector loads at that edge.
- Simultaneous events: completion coinciding with an output handshake loads the new vector with no bubble; m_valid stays 1.
- drop_cnt saturates at 2^DROP_W-1 and never wraps.
- Throughput: one beat per cycle sustained when m_ready=1; one frame per BEATS cycles.

Test Plan:
- Reset, then 12 beats with s_sof on beat 0, s_data=8'hE4 each, m_ready=1. Required:
  - m_valid rises at the edge accepting beat 11.
  - m_data = {12{8'hE4}}.
  - s_ready stays 1 throughout.
  - drop_cnt=0.
- Two back-to-back frames (A: beat k data=k, B: data=8'hFF-k), m_ready=0 until 30 cycles later. Required:
  - Frame A is held on m_data.
  - Frame B completes and enters HOLD; s_ready=0.
  - Raising m_ready: A handshakes, B appears the next cycle with no bubble, s_ready returns to 1.
- s_sof reasserted at beat 5, then 12 clean beats. Required: drop_cnt=1; exactly one output vector, equal to the clean frame.
- 3 beats with s_sof=0 from IDLE, then a valid frame. Required: drop_cnt=3; one correct output vector.
- rst asserted mid-frame at beat 7 with m_valid=1. Required:
  - m_valid=0 and drop_cnt=0 immediately, without waiting for a clock edge.
  - A subsequent full frame is output correctly.
- 300 stray non-sof beats. Required: drop_cnt saturates at 255.
